decoder_nxm_seq: RTL and testbench
==================================

# decoder_nxm_seq

Parametrised, registered successor to the 3-to-8 decoder. It drives a one-hot output vector of NUM_OUT lines from either a handshaked address stream (direct mode) or an internal scan sequencer that walks every output with a programmable dwell. It sits between control logic and per-line selects such as LED banks, chip-selects or mux enables, wherever a glitch-free registered one-hot is required.

## Interface
- ADDR_W, 3: address width.
- NUM_OUT, 8: number of one-hot outputs; 2 ≤ NUM_OUT ≤ 2**ADDR_W.
- DWELL_W, 8: width of the dwell count.
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  direct-mode address valid.
- in_ready  out  1  direct-mode ready.
- in_addr  in  ADDR_W  direct-mode address.
- mode  in  1  0 = direct, 1 = scan; sampled only with start.
- start  in  1  begin scan; acts only in IDLE with mode=1.
- stop  in  1  end scan.
- dwell  in  DWELL_W  each scan position is held dwell+1 cycles; sampled at start.
- out_onehot  out  NUM_OUT  registered one-hot, or all-zero.
- out_addr  out  ADDR_W  index currently asserted.
- out_valid  out  1  one-cycle pulse on every out_onehot update.
- err  out  1  one-cycle pulse when in_addr ≥ NUM_OUT is accepted.
- busy  out  1  high while in SCAN.

## Operation
- States: IDLE, SCAN.
- in_ready = (state==IDLE) && !(start && mode). This is combinational and contains no path from in_valid.
- Direct accept (in_valid && in_ready):
  - Next cycle: out_onehot = 1<<in_addr, out_addr = in_addr, out_valid = 1.
  - The pattern then holds until the next accept.
- Out-of-range accept: out_onehot = 0, out_addr = in_addr, out_valid = 1, err = 1, all in the same cycle.
- IDLE → SCAN on start && mode:
  - Latch dwell; index = 0.
  - Next cycle: out_onehot = 1, out_addr = 0, out_valid = 1, busy = 1.
- SCAN:
  - The dwell counter counts 0..dwell_latched.
  - At terminal count: index advances, out_valid pulses, and the counter clears.
  - Index wraps from NUM_OUT-1 to 0.
- SCAN → IDLE on stop: next cycle out_onehot = 0, out_addr = 0, busy = 0, out_valid = 1.
- Simultaneous events:
  - stop and advance in the same cycle: stop wins, with no advance.
  - start && mode with in_valid in IDLE: scan wins and the address is not accepted.
  - stop in IDLE: ignored.
  - start in SCAN: ignored.
- Reset (including mid-scan): state = IDLE; out_onehot, out_addr, out_valid, err, busy = 0; counters = 0. in_ready returns to 1 after release.

## Timing
- Direct latency: 1 cycle from handshake edge to output. Back-to-back accepts update every cycle.
- Scan start at edge k: position 0 is visible from k+1. Position n is visible from k+1+n·(dwell+1).
- dwell = 0: scan advances every cycle.
- Stop at edge k: outputs are cleared from k+1.
- All outputs are registered. out_onehot never has more than one bit set.

## Configuration
- SCAN_DECODER_SCAN_EN defined: full scan mode as described above.
- SCAN_DECODER_SCAN_EN undefined:
  - SCAN state, dwell counter and scan index are not built.
  - mode, start, stop and dwell remain ports but are ignored.
  - busy is tied to 0 and in_ready = 1 permanently.
  - Direct mode behaviour is unchanged.

## Structure
- Package dec_pkg holds:
  - the state enum (IDLE, SCAN);
  - mode constants MODE_DIRECT = 0 and MODE_SCAN = 1.
- Sub-module scan_index_counter contains the dwell counter plus the wrapping index. It is parametrised by ADDR_W, NUM_OUT and DWELL_W, and has ports for load, clear and advance pulse. It is instantiated only under SCAN_DECODER_SCAN_EN.
- The top level holds the FSM, the direct-mode path and the output registers.

## Test plan
- Reset with defaults: all outputs 0 and in_ready = 1. Accept addr 5 → next cycle out_onehot = 8'b0010_0000, out_valid pulse.
- Back-to-back accepts 0, 7, 3 → out_onehot = 0x01, 0x80, 0x08 on consecutive cycles, with 3 out_valid pulses.
- NUM_OUT = 6, accept addr 6 → out_onehot = 0, err and out_valid pulse together.
- Scan with dwell = 2:
  - out_addr follows 0,0,0,1,1,1,…,7,7,7,0.
  - out_valid pulses every 3rd cycle.
  - in_ready = 0 throughout.
- Stop coinciding with a terminal count → no advance; out_onehot = 0 next cycle, busy = 0.
- Assert rst_n low mid-scan at position 4 → outputs 0 immediately. After release, a direct accept of addr 2 works normally.

Source files
------------

// File: rtl/decoder_nxm_seq_pkg.sv
// Shared types for the registered N-to-M decoder: FSM state encoding and mode values.
package dec_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/decoder_nxm_seq_scan_index_counter.sv
// Dwell timer plus wrapping scan index for decoder_nxm_seq.
// The dwell timer is a down-counter reloaded with the latched dwell; reaching
// zero is the terminal count that advances the index.
module scan_index_counter #(
  parameter int ADDR_W  = 3,
  parameter int NUM_OUT = 8,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               clear,
  input  logic               run,
  input  logic [DWELL_W-1:0] dwell,
  output logic               advance,
  output logic [ADDR_W-1:0]  index,
  output logic [ADDR_W-1:0]  index_nxt
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_OUT - 1);

  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] cnt;

  // clear (stop) suppresses the advance that would otherwise fire on the same edge
  assign advance   = run && (cnt == '0) && !clear;
  assign index_nxt = (index == LAST) ? '0 : index + 1'b1;

  // dwell latch, down-counter and wrapping index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q <= '0;
      cnt     <= '0;
      index   <= '0;
    end else if (load) begin
      dwell_q <= dwell;
      cnt     <= dwell;
      index   <= '0;
    end else if (clear) begin
      cnt     <= '0;
      index   <= '0;
    end else if (advance) begin
      cnt     <= dwell_q;
      index   <= index_nxt;
    end else if (run) begin
      cnt     <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/decoder_nxm_seq.sv
// Registered one-hot decoder with handshaked direct mode and optional scan sequencer.
// Build option: define SCAN_DECODER_SCAN_EN to include the scan FSM and counter;
// without it the block is a pure registered direct-mode decoder.
//
// state | meaning
// IDLE  | direct mode, addresses accepted when in_valid
// SCAN  | sequencer walks outputs 0..NUM_OUT-1 with dwell+1 cycles per step
module decoder_nxm_seq
  import dec_pkg::*;
#(
  parameter int ADDR_W  = 3,
  parameter int NUM_OUT = 8,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  in_addr,
  input  logic               mode,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
  output logic [NUM_OUT-1:0] out_onehot,
  output logic [ADDR_W-1:0]  out_addr,
  output logic               out_valid,
  output logic               err,
  output logic               busy
);

  logic               accept;
  logic               in_range;
  logic [NUM_OUT-1:0] dec_direct;
  logic [NUM_OUT-1:0] dec_scan;
  logic               scan_start;
  logic               scan_stop;
  logic               scan_adv;
  logic [ADDR_W-1:0]  scan_next;

`ifdef SCAN_DECODER_SCAN_EN
  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] scan_index;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state decode; scan start beats a simultaneous direct request
  always_comb begin
    state_nxt  = state;
    scan_start = 1'b0;
    scan_stop  = 1'b0;
    case (state)
      IDLE: if (start && (mode == MODE_SCAN)) begin
        state_nxt  = SCAN;
        scan_start = 1'b1;
      end
      SCAN: if (stop) begin
        state_nxt = IDLE;
        scan_stop = 1'b1;
      end
    endcase
  end

  assign in_ready = (state == IDLE) && !(start && (mode == MODE_SCAN));
  assign busy     = (state == SCAN);

  scan_index_counter #(
    .ADDR_W  (ADDR_W),
    .NUM_OUT (NUM_OUT),
    .DWELL_W (DWELL_W)
  ) u_scan_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (scan_start),
    .clear     (scan_stop),
    .run       (state == SCAN),
    .dwell     (dwell),
    .advance   (scan_adv),
    .index     (scan_index),
    .index_nxt (scan_next)
  );

  logic unused_scan;
  assign unused_scan = ^scan_index;
`else
  assign in_ready   = 1'b1;
  assign busy       = 1'b0;
  assign scan_start = 1'b0;
  assign scan_stop  = 1'b0;
  assign scan_adv   = 1'b0;
  assign scan_next  = '0;

  logic unused_scan;
  assign unused_scan = ^{mode, start, stop, dwell};
`endif

  assign accept   = in_valid && in_ready;
  assign in_range = ({1'b0, in_addr} < (ADDR_W + 1)'(NUM_OUT));

  // one-hot decode of the direct address and of the next scan position
  always_comb begin
    dec_direct = '0;
    dec_scan   = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      dec_direct[i] = in_range && (in_addr == ADDR_W'(i));
      dec_scan[i]   = (scan_next == ADDR_W'(i));
    end
  end

  // output registers; out_valid and err are single-cycle pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_onehot <= '0;
      out_addr   <= '0;
      out_valid  <= 1'b0;
      err        <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      err       <= 1'b0;
      if (scan_start) begin
        out_onehot <= NUM_OUT'(1);
        out_addr   <= '0;
        out_valid  <= 1'b1;
      end else if (scan_stop) begin
        out_onehot <= '0;
        out_addr   <= '0;
        out_valid  <= 1'b1;
      end else if (scan_adv) begin
        out_onehot <= dec_scan;
        out_addr   <= scan_next;
        out_valid  <= 1'b1;
      end else if (accept) begin
        out_onehot <= dec_direct;
        out_addr   <= in_addr;
        out_valid  <= 1'b1;
        err        <= !in_range;
      end
    end
  end

endmodule

// File: tb/tb_decoder_nxm_seq.sv
// Directed bench for decoder_nxm_seq: default 8-output instance plus a 6-output
// instance for the out-of-range path. Scan checks build when SCAN_DECODER_SCAN_EN is defined.
module tb_decoder_nxm_seq;
  import dec_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_addr;
  logic       mode;
  logic       start;
  logic       stop;
  logic [7:0] dwell;
  logic [7:0] out_onehot;
  logic [2:0] out_addr;
  logic       out_valid;
  logic       err;
  logic       busy;

  logic       valid6;
  logic       ready6;
  logic [2:0] addr6;
  logic [5:0] onehot6;
  logic [2:0] out_addr6;
  logic       out_valid6;
  logic       err6;
  logic       busy6;

  int tests_run;
  int tests_failed;

  decoder_nxm_seq #(.ADDR_W(3), .NUM_OUT(8), .DWELL_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .mode       (mode),
    .start      (start),
    .stop       (stop),
    .dwell      (dwell),
    .out_onehot (out_onehot),
    .out_addr   (out_addr),
    .out_valid  (out_valid),
    .err        (err),
    .busy       (busy)
  );

  decoder_nxm_seq #(.ADDR_W(3), .NUM_OUT(6), .DWELL_W(8)) dut6 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (valid6),
    .in_ready   (ready6),
    .in_addr    (addr6),
    .mode       (1'b0),
    .start      (1'b0),
    .stop       (1'b0),
    .dwell      (8'd0),
    .out_onehot (onehot6),
    .out_addr   (out_addr6),
    .out_valid  (out_valid6),
    .err        (err6),
    .busy       (busy6)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] seq_addr [3];
    logic [7:0] seq_hot  [3];
    int p;
    tests_run    = 0;
    tests_failed = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_addr  = '0;
    mode     = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    dwell    = '0;
    valid6   = 1'b0;
    addr6    = '0;

    // reset state
    tick(); tick();
    chk("rst_hot",   out_onehot, 0);
    chk("rst_addr",  out_addr,   0);
    chk("rst_valid", out_valid,  0);
    chk("rst_err",   err,        0);
    chk("rst_busy",  busy,       0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", in_ready, 1);

    // single direct accept
    in_valid = 1'b1; in_addr = 3'd5;
    #1 chk("acc5_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("acc5_hot",   out_onehot, 8'h20);
    chk("acc5_addr",  out_addr,   5);
    chk("acc5_valid", out_valid,  1);
    chk("acc5_err",   err,        0);
    tick();
    chk("acc5_hold_hot",   out_onehot, 8'h20);
    chk("acc5_hold_valid", out_valid,  0);

    // back-to-back accepts
    seq_addr[0] = 3'd0; seq_hot[0] = 8'h01;
    seq_addr[1] = 3'd7; seq_hot[1] = 8'h80;
    seq_addr[2] = 3'd3; seq_hot[2] = 8'h08;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_addr = seq_addr[i];
      tick();
      chk("b2b_hot",   out_onehot, seq_hot[i]);
      chk("b2b_addr",  out_addr,   seq_addr[i]);
      chk("b2b_valid", out_valid,  1);
      chk("b2b_err",   err,        0);
    end
    in_valid = 1'b0;
    tick();
    chk("b2b_idle_valid", out_valid,  0);
    chk("b2b_idle_hot",   out_onehot, 8'h08);

    // NUM_OUT = 6: top in-range address, then out-of-range
    valid6 = 1'b1; addr6 = 3'd5;
    tick();
    chk("n6_hot5", onehot6, 6'h20);
    chk("n6_err5", err6,    0);
    addr6 = 3'd6;
    tick();
    valid6 = 1'b0;
    chk("n6_hot6",   onehot6,    0);
    chk("n6_addr6",  out_addr6,  6);
    chk("n6_err6",   err6,       1);
    chk("n6_valid6", out_valid6, 1);
    tick();
    chk("n6_err_pulse",   err6,       0);
    chk("n6_valid_pulse", out_valid6, 0);
    chk("n6_hold_hot",    onehot6,    0);
    chk("n6_ready",       ready6,     1);
    chk("n6_busy",        busy6,      0);

`ifdef SCAN_DECODER_SCAN_EN
    // scan with dwell 2; a simultaneous direct request loses to start
    dwell = 8'd2; mode = 1'b1; start = 1'b1; in_valid = 1'b1; in_addr = 3'd6;
    #1 chk("start_ready", in_ready, 0);
    tick();
    start = 1'b0; in_valid = 1'b0; mode = 1'b0;
    for (int c = 0; c < 27; c++) begin
      p = (c / 3) % 8;
      chk("scan_addr",  out_addr,   p);
      chk("scan_hot",   out_onehot, 1 << p);
      chk("scan_valid", out_valid,  (c % 3 == 0) ? 1 : 0);
      chk("scan_ready", in_ready,   0);
      chk("scan_busy",  busy,       1);
      if (c == 10) begin
        start = 1'b1; mode = 1'b1;
      end else begin
        start = 1'b0; mode = 1'b0;
      end
      if (c < 26) tick();
    end
    // stop on a terminal-count edge: no advance, outputs cleared
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_hot",   out_onehot, 0);
    chk("stop_addr",  out_addr,   0);
    chk("stop_busy",  busy,       0);
    chk("stop_valid", out_valid,  1);
    chk("stop_ready", in_ready,   1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("idle_stop_valid", out_valid, 0);
    chk("idle_stop_busy",  busy,      0);

    // dwell 0 advances every cycle and wraps
    dwell = 8'd0; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; mode = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk("d0_addr",  out_addr,  c % 8);
      chk("d0_valid", out_valid, 1);
      if (c < 9) tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("d0_stop_busy", busy, 0);

    // reset mid-scan at position 4
    dwell = 8'd1; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; mode = 1'b0;
    repeat (8) tick();
    chk("pre_rst_addr", out_addr,   4);
    chk("pre_rst_hot",  out_onehot, 8'h10);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_hot",   out_onehot, 0);
    chk("mid_rst_addr",  out_addr,   0);
    chk("mid_rst_busy",  busy,       0);
    chk("mid_rst_valid", out_valid,  0);
    tick();
    rst_n = 1'b1;
    #1 chk("post_rst_ready", in_ready, 1);
`else
    // scan controls have no effect in the direct-only build
    mode = 1'b1; start = 1'b1; dwell = 8'd2; in_valid = 1'b1; in_addr = 3'd4;
    #1 chk("noscan_ready", in_ready, 1);
    tick();
    mode = 1'b0; start = 1'b0; in_valid = 1'b0;
    chk("noscan_hot",   out_onehot, 8'h10);
    chk("noscan_valid", out_valid,  1);
    chk("noscan_busy",  busy,       0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("noscan_stop_hot",   out_onehot, 8'h10);
    chk("noscan_stop_valid", out_valid,  0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_hot",  out_onehot, 0);
    chk("mid_rst_addr", out_addr,   0);
    tick();
    rst_n = 1'b1;
    #1 chk("post_rst_ready", in_ready, 1);
`endif

    // direct mode works normally after reset
    in_valid = 1'b1; in_addr = 3'd2;
    tick();
    in_valid = 1'b0;
    chk("post_rst_hot",   out_onehot, 8'h04);
    chk("post_rst_addr",  out_addr,   2);
    chk("post_rst_valid", out_valid,  1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
